// File: rtl/display_ctrl.sv
// display_ctrl: shares the 4-digit BCD display between keypad entry and calculator results,
// enforces a minimum result hold and blinks an error glyph. Define LZB_EN for leading-zero blanking.
module display_ctrl #(
    parameter int unsigned HOLD_CYCLES  = 2**26 - 1,
    parameter int unsigned BLINK_PERIOD = 2**24 - 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        entry_valid,
    input  logic [15:0] entry_digits,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [15:0] res_digits,
    input  logic        res_error,
    output logic [3:0]  number_0,
    output logic [3:0]  number_1,
    output logic [3:0]  number_2,
    output logic [3:0]  number_3,
    output logic        showing_result
);

    localparam int HOLD_W  = (HOLD_CYCLES  > 0) ? $clog2(HOLD_CYCLES + 1)  : 1;
    localparam int BLINK_W = (BLINK_PERIOD > 0) ? $clog2(BLINK_PERIOD + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        SHOW_ENTRY,
        SHOW_RESULT,
        SHOW_ERROR
    } state_t;

`ifdef LZB_EN
    function automatic logic [15:0] format_digits(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[15:12] == 4'h0)  r[15:12] = 4'hF;
        if (v[15:8]  == 8'h00) r[11:8]  = 4'hF;
        if (v[15:4]  == 12'h0) r[7:4]   = 4'hF;
        return r;
    endfunction
    localparam logic [15:0] RESET_DISP = 16'hFFF0;
`else
    function automatic logic [15:0] format_digits(input logic [15:0] v);
        return v;
    endfunction
    localparam logic [15:0] RESET_DISP = 16'h0000;
`endif

    state_t              state, state_nx;
    logic [15:0]         value, value_nx;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
    logic                hold_expired, hold_expired_nx;
    logic [BLINK_W-1:0]  blink_cnt, blink_cnt_nx;
    logic                blink_phase, blink_phase_nx;
    logic                accept;
    logic [15:0]         disp_nx, disp_p1;
    logic                showing_nx;

    always_comb begin
        state_nx        = state;
        value_nx        = value;
        hold_cnt_nx     = hold_cnt;
        hold_expired_nx = hold_expired;
        blink_cnt_nx    = blink_cnt;
        blink_phase_nx  = blink_phase;
        res_ready       = 1'b1;

        case (state)
            SHOW_RESULT: res_ready = hold_expired;
            SHOW_ERROR:  res_ready = 1'b0;
            default:     res_ready = 1'b1;
        endcase
        accept = res_valid && res_ready;

        // free-running timers, overridden below by accept/clear
        if (state == SHOW_RESULT && !hold_expired) begin
            if (hold_cnt == HOLD_LAST) hold_expired_nx = 1'b1;
            else                       hold_cnt_nx     = hold_cnt + HOLD_W'(1);
        end
        if (state == SHOW_ERROR) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nx   = '0;
                blink_phase_nx = ~blink_phase;
            end else begin
                blink_cnt_nx = blink_cnt + BLINK_W'(1);
            end
        end

        if (clear) begin
            state_nx        = IDLE;
            value_nx        = 16'h0000;
            hold_cnt_nx     = '0;
            hold_expired_nx = 1'b0;
            blink_cnt_nx    = '0;
            blink_phase_nx  = 1'b0;
        end else if (accept && !res_error) begin
            state_nx        = SHOW_RESULT;
            value_nx        = res_digits;
            hold_cnt_nx     = '0;
            hold_expired_nx = 1'b0;
        end else if (accept) begin
            state_nx       = SHOW_ERROR;
            blink_cnt_nx   = '0;
            blink_phase_nx = 1'b0;
        end else begin
            case (state)
                IDLE, SHOW_ENTRY: begin
                    if (entry_valid) begin
                        state_nx = SHOW_ENTRY;
                        value_nx = entry_digits;
                    end
                end
                SHOW_RESULT: begin
                    if (hold_expired && entry_valid) begin
                        state_nx = SHOW_ENTRY;
                        value_nx = entry_digits;
                    end
                end
                default: state_nx = state;
            endcase
        end

        if (state == SHOW_ERROR) disp_nx = blink_phase ? 16'hFFFF : 16'hFFFE;
        else                     disp_nx = format_digits(value);
        showing_nx = (state == SHOW_RESULT) || (state == SHOW_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            value          <= 16'h0000;
            hold_cnt       <= '0;
            hold_expired   <= 1'b0;
            blink_cnt      <= '0;
            blink_phase    <= 1'b0;
            disp_p1        <= RESET_DISP;
            showing_result <= 1'b0;
        end else begin
            state          <= state_nx;
            value          <= value_nx;
            hold_cnt       <= hold_cnt_nx;
            hold_expired   <= hold_expired_nx;
            blink_cnt      <= blink_cnt_nx;
            blink_phase    <= blink_phase_nx;
            // output stage: one clock behind state/value
            disp_p1        <= disp_nx;
            showing_result <= showing_nx;
        end
    end

    assign number_0 = disp_p1[3:0];
    assign number_1 = disp_p1[7:4];
    assign number_2 = disp_p1[11:8];
    assign number_3 = disp_p1[15:12];

endmodule

// File: tb/tb_display_ctrl.sv
// Bench for display_ctrl: directed scenarios with literal checks plus a per-cycle model comparison.
module tb_display_ctrl;

    localparam int HOLD  = 7;
    localparam int BLINK = 3;
    localparam int M_IDLE = 0, M_ENTRY = 1, M_RES = 2, M_ERR = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        entry_valid = 1'b0;
    logic [15:0] entry_digits = 16'h0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [15:0] res_digits = 16'h0;
    logic        res_error = 1'b0;
    logic [3:0]  number_0, number_1, number_2, number_3;
    logic        showing_result;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    display_ctrl #(.HOLD_CYCLES(HOLD), .BLINK_PERIOD(BLINK)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .entry_valid(entry_valid), .entry_digits(entry_digits),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_digits(res_digits), .res_error(res_error),
        .number_0(number_0), .number_1(number_1),
        .number_2(number_2), .number_3(number_3),
        .showing_result(showing_result)
    );

    always #5 clk = ~clk;

    // model: mode, shown value, cycles of hold left, cycles spent in error
    int          m_mode = M_IDLE;
    logic [15:0] m_val = 16'h0;
    int          m_hold_left = 0;
    int          m_err_age = 0;
    logic [15:0] m_out = 16'h0;
    logic        m_sr = 1'b0;

    function automatic logic [15:0] show(input int mode, input logic [15:0] v, input int age);
        logic [15:0] r;
        bit lead;
        if (mode == M_ERR) return (((age / (BLINK + 1)) % 2) == 0) ? 16'hFFFE : 16'hFFFF;
        r = v;
        lead = 1'b1;
`ifdef LZB_EN
        for (int d = 3; d >= 1; d--) begin
            lead = lead && (v[d*4 +: 4] == 4'h0);
            if (lead) r[d*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic bit ready_m();
        if (m_mode == M_ERR) return 1'b0;
        if (m_mode == M_RES) return m_hold_left == 0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode <= M_IDLE; m_val <= 16'h0; m_hold_left <= 0; m_err_age <= 0;
            m_out <= show(M_IDLE, 16'h0, 0); m_sr <= 1'b0;
        end else begin
            m_out <= show(m_mode, m_val, m_err_age);
            m_sr  <= (m_mode == M_RES) || (m_mode == M_ERR);
            if (clear) begin
                m_mode <= M_IDLE; m_val <= 16'h0; m_hold_left <= 0; m_err_age <= 0;
            end else if (res_valid && ready_m()) begin
                if (!res_error) begin
                    m_mode <= M_RES; m_val <= res_digits; m_hold_left <= HOLD + 1;
                end else begin
                    m_mode <= M_ERR; m_err_age <= 0;
                end
            end else if (m_mode == M_IDLE || m_mode == M_ENTRY) begin
                if (entry_valid) begin m_mode <= M_ENTRY; m_val <= entry_digits; end
            end else if (m_mode == M_RES) begin
                if (m_hold_left == 0 && entry_valid) begin
                    m_mode <= M_ENTRY; m_val <= entry_digits;
                end else if (m_hold_left > 0) begin
                    m_hold_left <= m_hold_left - 1;
                end
            end else begin
                m_err_age <= m_err_age + 1;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ready", {15'h0, res_ready}, {15'h0, ready_m()});
            check("cyc_digits", {number_3, number_2, number_1, number_0}, m_out);
            check("cyc_showing", {15'h0, showing_result}, {15'h0, m_sr});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [15:0] raw, input logic [15:0] lzb);
        logic [15:0] e;
`ifdef LZB_EN
        e = lzb;
`else
        e = raw;
`endif
        check({name, "_dut"}, {number_3, number_2, number_1, number_0}, e);
        check({name, "_model"}, m_out, e);
    endtask

    task automatic count_hold(input string name);
        int n;
        n = 0;
        for (int k = 0; k < 20 && res_ready == 1'b0; k++) begin
            n++;
            cyc(1);
        end
        check(name, 16'(n), 16'd8);
    endtask

    initial begin
        // reset state
        cyc(2);
        chk_en = 1'b1;
        lit("reset_digits", 16'h0000, 16'hFFF0);
        check("reset_ready", {15'h0, res_ready}, 16'h1);
        check("reset_showing", {15'h0, showing_result}, 16'h0);
        reset = 1'b0;
        cyc(2);
        lit("idle_digits", 16'h0000, 16'hFFF0);

        // keypad entry
        entry_valid = 1'b1; entry_digits = 16'h0042;
        cyc(2);
        lit("entry_0042", 16'h0042, 16'hFF42);
        check("entry_showing", {15'h0, showing_result}, 16'h0);

        // result beats entry, hold ignores entry until it expires
        res_valid = 1'b1; res_digits = 16'h1234;
        cyc(1);
        res_valid = 1'b0; entry_digits = 16'h0777;
        count_hold("hold_len");
        lit("result_1234", 16'h1234, 16'h1234);
        check("result_showing", {15'h0, showing_result}, 16'h1);
        cyc(2);
        lit("entry_resume", 16'h0777, 16'hF777);

        // error blink; a second offer is refused
        entry_valid = 1'b0;
        res_valid = 1'b1; res_error = 1'b1; res_digits = 16'h9999;
        cyc(1);
        res_error = 1'b0; res_digits = 16'h5555;
        cyc(1);
        lit("err_ph0", 16'hFFFE, 16'hFFFE);
        check("err_ready", {15'h0, res_ready}, 16'h0);
        cyc(4);
        lit("err_ph1", 16'hFFFF, 16'hFFFF);
        cyc(4);
        lit("err_ph0_again", 16'hFFFE, 16'hFFFE);
        res_valid = 1'b0; clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(1);
        lit("err_cleared", 16'h0000, 16'hFFF0);

        // clear beats a same-cycle accept
        res_valid = 1'b1; res_digits = 16'h4321; clear = 1'b1;
        cyc(1);
        res_valid = 1'b0; clear = 1'b0;
        cyc(2);
        lit("clear_drop", 16'h0000, 16'hFFF0);
        check("clear_showing", {15'h0, showing_result}, 16'h0);

        // reset mid-hold, then a fresh result gets a full hold
        res_valid = 1'b1; res_digits = 16'h0567;
        cyc(1);
        res_valid = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        lit("midhold_reset", 16'h0000, 16'hFFF0);
        check("midhold_ready", {15'h0, res_ready}, 16'h1);
        reset = 1'b0; res_valid = 1'b1; res_digits = 16'h0890;
        cyc(1);
        res_valid = 1'b0;
        count_hold("hold_after_reset");
        lit("result_0890", 16'h0890, 16'hF890);

        // non-BCD pass-through and inner zeros
        entry_valid = 1'b1; entry_digits = 16'h00B0;
        cyc(2);
        lit("entry_00B0", 16'h00B0, 16'hFFB0);
        entry_digits = 16'h0300;
        cyc(2);
        lit("entry_0300", 16'h0300, 16'hF300);
        entry_valid = 1'b0; entry_digits = 16'h9999;
        cyc(2);
        lit("entry_frozen", 16'h0300, 16'hF300);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
